// File: rtl/fifo_frame_writer_pkg.sv
// Shared framing definitions for the async_fifo writer/deframer pair.
// State encoding, sync nibble and trailer bit layout live here so both sides agree.
package fifo_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_T_HI    = 3'd2,
    ST_T_LO    = 3'd3,
    ST_T_SUM   = 3'd4,
    ST_DISCARD = 3'd5
  } fw_state_e;

  localparam logic [3:0] SYNC_DEF   = 4'hA;
  localparam int         TRUNC_BIT  = 7;
  localparam int         LEN_HI_MSB = 3;
  localparam int         LEN_HI_LSB = 0;

  // First trailer byte: truncation flag plus the top nibble of the 12-bit length.
  function automatic logic [7:0] t_hi_byte(input logic trunc, input logic [11:0] len);
    logic [7:0] b;
    b = '0;
    b[TRUNC_BIT] = trunc;
    b[LEN_HI_MSB:LEN_HI_LSB] = len[11:8];
    return b;
  endfunction

endpackage

// File: rtl/fifo_frame_writer_acc.sv
// Per-frame accumulator: 12-bit data length and running XOR checksum.
module frame_acc
  import fifo_frame_writer_pkg::*;
(
  input  logic        wclk,
  input  logic        dir_clr_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [11:0] len,
  output logic [7:0]  sum
);

  logic [11:0] len_q, len_d;
  logic [7:0]  sum_q, sum_d;

  always_comb begin
    len_d = len_q;
    sum_d = sum_q;
    if (clr) begin
      len_d = '0;
      sum_d = '0;
    end else if (en) begin
      len_d = len_q + 12'd1;
      sum_d = sum_q ^ din;
    end
  end

  always_ff @(posedge wclk or negedge dir_clr_n) begin
    if (!dir_clr_n) begin
      len_q <= '0;
      sum_q <= '0;
    end else begin
      len_q <= len_d;
      sum_q <= sum_d;
    end
  end

  assign len = len_q;
  assign sum = sum_q;

endmodule

// File: rtl/fifo_frame_writer.sv
// Write-side framer: wraps a byte stream as header / data / len+checksum trailer
// and pushes it into async_fifo, stalling on wfull and truncating at MAXLEN.
module fifo_frame_writer
  import fifo_frame_writer_pkg::*;
#(
  parameter int         MAXLEN = 1500,
  parameter logic [3:0] SYNC   = SYNC_DEF
) (
  input  logic        wclk,
  input  logic        dir_clr_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        wr,
  output logic [7:0]  wdata,
  input  logic        wfull,
  output logic        busy,
  output logic [15:0] frm_cnt,
  output logic        trunc_err
);

  localparam logic [12:0] MAX_W = 13'(MAXLEN);

  fw_state_e   state_q, state_d;
  logic [3:0]  seq_q, seq_d;
  logic        trunc_q, trunc_d;
  logic        trunc_err_q, trunc_err_d;
  logic [15:0] frm_cnt_q, frm_cnt_d;

  logic        acc_clr, acc_en, want_wr, accept;
  logic [7:0]  wdata_mux;
  logic [11:0] len;
  logic [7:0]  sum;

  frame_acc u_acc (
    .wclk      (wclk),
    .dir_clr_n (dir_clr_n),
    .clr       (acc_clr),
    .en        (acc_en),
    .din       (s_data),
    .len       (len),
    .sum       (sum)
  );

  assign accept = s_valid & s_ready;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    trunc_d     = trunc_q;
    trunc_err_d = trunc_err_q;
    frm_cnt_d   = frm_cnt_q;
    s_ready     = 1'b0;
    want_wr     = 1'b0;
    wdata_mux   = '0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        want_wr   = s_valid;
        wdata_mux = {SYNC, seq_q};
        if (s_valid && !wfull) begin
          acc_clr = 1'b1;
          trunc_d = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Data bytes pass straight through, so ready and write share the wfull stall.
        s_ready   = ~wfull;
        want_wr   = s_valid;
        wdata_mux = s_data;
        if (accept) begin
          acc_en = 1'b1;
          if (s_last) begin
            state_d = ST_T_HI;
          end else if (({1'b0, len} + 13'd1) == MAX_W) begin
            trunc_d     = 1'b1;
            trunc_err_d = 1'b1;
            state_d     = ST_T_HI;
          end
        end
      end
      ST_T_HI: begin
        want_wr   = 1'b1;
        wdata_mux = t_hi_byte(trunc_q, len);
        if (!wfull) state_d = ST_T_LO;
      end
      ST_T_LO: begin
        want_wr   = 1'b1;
        wdata_mux = len[7:0];
        if (!wfull) state_d = ST_T_SUM;
      end
      ST_T_SUM: begin
        want_wr   = 1'b1;
        wdata_mux = sum;
        if (!wfull) begin
          seq_d     = seq_q + 4'd1;
          frm_cnt_d = frm_cnt_q + 16'd1;
          state_d   = trunc_q ? ST_DISCARD : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        s_ready = 1'b1;
        if (accept && s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge dir_clr_n) begin
    if (!dir_clr_n) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      trunc_q     <= 1'b0;
      trunc_err_q <= 1'b0;
      frm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      trunc_q     <= trunc_d;
      trunc_err_q <= trunc_err_d;
      frm_cnt_q   <= frm_cnt_d;
    end
  end

  assign wr        = want_wr & ~wfull;
  assign wdata     = wr ? wdata_mux : 8'h00;
  assign busy      = (state_q != ST_IDLE);
  assign frm_cnt   = frm_cnt_q;
  assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Randomized/directed bench for fifo_frame_writer; FIFO contents are compared
// against a frame-level model built from the source frames.
module tb_fifo_frame_writer;

  localparam int MAXL = 4;

  logic        wclk = 1'b0;
  logic        dir_clr_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        wr;
  logic [7:0]  wdata;
  logic        wfull = 1'b0;
  logic        busy;
  logic [15:0] frm_cnt;
  logic        trunc_err;

  always #5 wclk = ~wclk;

  fifo_frame_writer #(.MAXLEN(MAXL)) u_dut (
    .wclk      (wclk),
    .dir_clr_n (dir_clr_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .wr        (wr),
    .wdata     (wdata),
    .wfull     (wfull),
    .busy      (busy),
    .frm_cnt   (frm_cnt),
    .trunc_err (trunc_err)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] src[$];
  int         src_idx = 0;
  logic [7:0] frm_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [3:0] exp_seq = '0;
  logic [15:0] exp_frm = '0;
  logic       exp_trunc = 1'b0;
  bit         rand_vld = 0;
  bit         rand_full = 0;
  int         hold_at = -1;
  int         hold_len = 0;
  int         hold_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_src();
    for (int i = 0; i < frm_q.size(); i++)
      src.push_back({(i == frm_q.size() - 1), frm_q[i]});
  endtask

  // Frame-level model: header, first min(n,MAXL) bytes, trunc/len/xor trailer.
  task automatic add_frame();
    int n, k;
    logic [7:0] x;
    logic [11:0] kl;
    n = frm_q.size();
    k = (n > MAXL) ? MAXL : n;
    kl = 12'(k);
    x = '0;
    exp_q.push_back({4'hA, exp_seq});
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(frm_q[i]);
      x ^= frm_q[i];
    end
    exp_q.push_back({(n > MAXL), 3'b000, kl[11:8]});
    exp_q.push_back(kl[7:0]);
    exp_q.push_back(x);
    exp_seq++;
    exp_frm++;
    if (n > MAXL) exp_trunc = 1'b1;
    add_src();
  endtask

  task automatic cycle();
    bit holding;
    @(posedge wclk); #1;
    holding = 0;
    if (hold_at >= 0 && obs_q.size() == hold_at) begin
      hold_left = hold_len;
      hold_at = -1;
    end
    if (hold_left > 0) begin
      holding = 1;
      hold_left--;
    end
    wfull = holding ? 1'b1 : (rand_full ? ($urandom_range(0, 3) == 0) : 1'b0);
    if (src_idx < src.size() && (!rand_vld || $urandom_range(0, 4) != 0)) begin
      s_valid = 1'b1;
      {s_last, s_data} = src[src_idx];
    end else begin
      s_valid = 1'b0;
      s_last  = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
    end
    @(negedge wclk);
    if (holding) begin
      chk("hold_wr", 32'(wr), 32'd0);
      chk("hold_rdy", 32'(s_ready), 32'd0);
    end
    if (wfull) chk("wr_when_full", 32'(wr), 32'd0);
    if (wr) obs_q.push_back(wdata);
    else chk("wdata_idle", 32'(wdata), 32'd0);
    if (s_valid && s_ready) src_idx++;
  endtask

  task automatic run_check(input string tag);
    int cyc;
    bit done;
    int m;
    cyc = 0;
    done = 0;
    while (!done && cyc < 5000) begin
      cycle();
      cyc++;
      done = (src_idx == src.size()) && !busy && (obs_q.size() >= exp_q.size());
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_frm"}, 32'(frm_cnt), 32'(exp_frm));
    chk({tag, "_trerr"}, 32'(trunc_err), 32'(exp_trunc));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    obs_q.delete();
    exp_q.delete();
    src.delete();
    src_idx = 0;
  endtask

  task automatic do_reset(input string tag);
    @(posedge wclk); #1;
    dir_clr_n = 1'b0;
    s_valid = 1'b0;
    wfull = 1'b0;
    @(negedge wclk);
    chk({tag, "_wr"}, 32'(wr), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
    chk({tag, "_rdy"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frm"}, 32'(frm_cnt), 32'd0);
    chk({tag, "_trerr"}, 32'(trunc_err), 32'd0);
    @(posedge wclk); #1;
    dir_clr_n = 1'b1;
    exp_seq = '0;
    exp_frm = '0;
    exp_trunc = 1'b0;
    obs_q.delete();
    exp_q.delete();
    src.delete();
    src_idx = 0;
    hold_at = -1;
    hold_left = 0;
  endtask

  initial begin
    do_reset("rst0");

    // 3-byte frame, literal stream
    frm_q = '{8'h01, 8'h02, 8'h04};
    add_src();
    exp_q = '{8'hA0, 8'h01, 8'h02, 8'h04, 8'h00, 8'h03, 8'h07};
    exp_frm = 16'd1;
    exp_seq = 4'd1;
    run_check("t1");

    // truncation at MAXLEN=4, literal stream
    do_reset("rst1");
    frm_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    add_src();
    exp_q = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h04, 8'h04};
    exp_frm = 16'd1;
    exp_seq = 4'd1;
    exp_trunc = 1'b1;
    run_check("t2");

    // wfull held 5 cycles after the 2nd data byte
    do_reset("rst2");
    frm_q = '{8'h11, 8'h22, 8'h33};
    add_frame();
    hold_at = 3;
    hold_len = 5;
    run_check("t3");

    // exactly MAXLEN bytes with last: normal end
    frm_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    add_frame();
    run_check("tmax");

    // 17 one-byte frames: seq wraps
    do_reset("rst3");
    for (int f = 0; f < 17; f++) begin
      frm_q = '{8'(f * 7 + 3)};
      add_frame();
    end
    run_check("t4");

    // wfull in the T_LO cycle of a 2-byte frame
    frm_q = '{8'h5A, 8'hA5};
    add_frame();
    hold_at = 4;
    hold_len = 3;
    run_check("t6");

    // random frames, random valid gaps and wfull
    rand_vld = 1;
    rand_full = 1;
    for (int f = 0; f < 40; f++) begin
      frm_q.delete();
      for (int i = 0; i < $urandom_range(1, 7); i++) frm_q.push_back(8'($urandom));
      add_frame();
    end
    run_check("rnd");
    rand_vld = 0;
    rand_full = 0;

    // reset mid-frame after 2 data bytes
    frm_q = '{8'h01, 8'h02, 8'h03};
    add_frame();
    for (int c = 0; c < 50 && obs_q.size() < 3; c++) cycle();
    chk("t5_pre", 32'(obs_q.size()), 32'd3);
    do_reset("t5rst");
    frm_q = '{8'h9C};
    add_frame();
    run_check("t5post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
